// File: rtl/asip_hazard_pipe_pkg.sv
// Shared types for the ASIP E->M->W pipeline: forwarding selects and per-stage control bundle.
package asip_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic regWrite;
        logic memWrite;
        logic memToReg;
        logic pcSrc;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/asip_hazard_pipe_stage_reg.sv
// Generic pipeline register: synchronous active-low reset, clear-to-bubble, and hold when not enabled.
module pipe_stage_reg #(
    parameter int unsigned W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/asip_hazard_pipe.sv
// EX/MEM and MEM/WB pipeline registers with hazard unit (forwarding, load-use stall, branch flush),
// multi-cycle data-memory handshake and a saturating stall-cycle counter.
module asip_hazard_pipe
    import asip_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RA_W   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   ra1D,
    input  logic [RA_W-1:0]   ra2D,
    input  logic [RA_W-1:0]   ra1E,
    input  logic [RA_W-1:0]   ra2E,
    input  logic [RA_W-1:0]   WA3E,
    input  logic              regWriteE,
    input  logic              memWriteE,
    input  logic              memToRegE,
    input  logic              pcSrcE,
    input  logic [ADDR_W-1:0] aluResE,
    input  logic [DATA_W-1:0] wdE,
    input  logic [DATA_W-1:0] rdMemData,
    input  logic              memReady,
    input  logic              clrCnt,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        fwdAE,
    output logic [1:0]        fwdBE,
    output logic [ADDR_W-1:0] memAddrM,
    output logic [DATA_W-1:0] memWDM,
    output logic              memReqM,
    output logic              memWriteM,
    output logic [ADDR_W-1:0] aluOutM,
    output logic [RA_W-1:0]   WA3W,
    output logic              regWriteW,
    output logic              pcSrcW,
    output logic [DATA_W-1:0] resultW,
    output logic [CNT_W-1:0]  stallCnt
);

    localparam int unsigned CTRL_W = $bits(pipe_ctrl_t);
    localparam int unsigned MW     = CTRL_W + RA_W + ADDR_W + DATA_W;
    localparam int unsigned WW     = 3 + RA_W + ADDR_W + DATA_W;
    localparam logic [WW-1:0] W_BUBBLE =
        {CTRL_BUBBLE.regWrite, CTRL_BUBBLE.memToReg, CTRL_BUBBLE.pcSrc, {(WW-3){1'b0}}};

    pipe_ctrl_t        ctrlE, ctrlM;
    logic [RA_W-1:0]   WA3M;
    logic [DATA_W-1:0] wdM;
    logic [MW-1:0]     m_d, m_q;

    logic              memToRegW;
    logic [ADDR_W-1:0] aluOutW;
    logic [DATA_W-1:0] rdW, rd_in;
    logic [WW-1:0]     w_d, w_q;

    logic              memStall, loadUse, anyStall;
    fwd_sel_t          fwdA, fwdB;

    assign ctrlE = '{regWrite: regWriteE, memWrite: memWriteE, memToReg: memToRegE, pcSrc: pcSrcE};

    // EX/MEM: freezes while the memory access in M is outstanding
    assign m_d = {ctrlE, WA3E, aluResE, wdE};

    pipe_stage_reg #(.W(MW)) u_exmem (
        .clk (clk),
        .rst (rst),
        .en  (~memStall),
        .clr (1'b0),
        .d   (m_d),
        .q   (m_q)
    );

    assign {ctrlM, WA3M, aluOutM, wdM} = m_q;

    assign memAddrM  = aluOutM;
    assign memWDM    = wdM;
    assign memWriteM = ctrlM.memWrite;
    assign memReqM   = ctrlM.memWrite | ctrlM.memToReg;
    assign memStall  = memReqM & ~memReady;

    // MEM/WB: takes a bubble on every wait cycle so the stalled access is written back exactly once
    assign rd_in = ctrlM.memToReg ? rdMemData : '0;
    assign w_d   = {ctrlM.regWrite, ctrlM.memToReg, ctrlM.pcSrc, WA3M, aluOutM, rd_in};

    pipe_stage_reg #(.W(WW), .CLR_VAL(W_BUBBLE)) u_memwb (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (memStall),
        .d   (w_d),
        .q   (w_q)
    );

    assign {regWriteW, memToRegW, pcSrcW, WA3W, aluOutW, rdW} = w_q;

    assign resultW = memToRegW ? rdW : {{(DATA_W-ADDR_W){1'b0}}, aluOutW};

    assign loadUse = memToRegE & regWriteE & ((WA3E == ra1D) | (WA3E == ra2D));

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
        end else if (pcSrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (loadUse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_comb begin
        fwdA = FWD_RF;
        fwdB = FWD_RF;
        if (ctrlM.regWrite && (WA3M == ra1E)) begin
            fwdA = FWD_M;
        end else if (regWriteW && (WA3W == ra1E)) begin
            fwdA = FWD_W;
        end
        if (ctrlM.regWrite && (WA3M == ra2E)) begin
            fwdB = FWD_M;
        end else if (regWriteW && (WA3W == ra2E)) begin
            fwdB = FWD_W;
        end
    end

    assign fwdAE = fwdA;
    assign fwdBE = fwdB;

    assign anyStall = stallF | flushE | memStall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (clrCnt) begin
            stallCnt <= '0;
        end else if (anyStall && !(&stallCnt)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_asip_hazard_pipe.sv
// Self-checking bench for asip_hazard_pipe: hazard vector table, scoreboarded ALU chain,
// and directed load-use / memory-wait / branch / counter-saturation sequences.
module tb_asip_hazard_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra1D, ra2D, ra1E, ra2E, WA3E;
    logic        regWriteE, memWriteE, memToRegE, pcSrcE;
    logic [15:0] aluResE;
    logic [23:0] wdE, rdMemData;
    logic        memReady, clrCnt;
    logic        stallF, stallD, flushD, flushE;
    logic [1:0]  fwdAE, fwdBE;
    logic [15:0] memAddrM, aluOutM;
    logic [23:0] memWDM, resultW;
    logic        memReqM, memWriteM;
    logic [3:0]  WA3W;
    logic        regWriteW, pcSrcW;
    logic [3:0]  stallCnt;

    asip_hazard_pipe #(.DATA_W(24), .ADDR_W(16), .RA_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E), .WA3E(WA3E),
        .regWriteE(regWriteE), .memWriteE(memWriteE), .memToRegE(memToRegE), .pcSrcE(pcSrcE),
        .aluResE(aluResE), .wdE(wdE), .rdMemData(rdMemData), .memReady(memReady), .clrCnt(clrCnt),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .fwdAE(fwdAE), .fwdBE(fwdBE),
        .memAddrM(memAddrM), .memWDM(memWDM), .memReqM(memReqM), .memWriteM(memWriteM),
        .aluOutM(aluOutM), .WA3W(WA3W), .regWriteW(regWriteW), .pcSrcW(pcSrcW),
        .resultW(resultW), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [3:0] ra1D, ra2D, wa;
        logic       rw, m2r, pc;
        logic       sf, sd, fd, fe;
    } hz_t;

    typedef struct {
        logic        rw;
        logic [3:0]  wa, ra1, ra2;
        logic [15:0] res;
        logic [1:0]  fa, fb;
    } instr_t;

    typedef struct {
        int          due;
        logic        rw;
        logic [3:0]  wa;
        logic [23:0] res;
    } wexp_t;

    hz_t    hz[8];
    instr_t prog[8];
    wexp_t  sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_e();
        ra1E = '0; ra2E = '0; WA3E = '0;
        regWriteE = 1'b0; memWriteE = 1'b0; memToRegE = 1'b0; pcSrcE = 1'b0;
        aluResE = '0; wdE = '0;
    endtask

    task automatic pop_due();
        wexp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("sb_regWriteW", regWriteW, e.rw);
            chk("sb_WA3W", WA3W, e.wa);
            chk("sb_resultW", resultW, e.res);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // ra1D, ra2D, WA3E, regWriteE, memToRegE, pcSrcE -> stallF, stallD, flushD, flushE
        hz[0] = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        hz[1] = '{4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        hz[2] = '{4'd1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        hz[3] = '{4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        hz[4] = '{4'd3, 4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        hz[5] = '{4'd3, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        hz[6] = '{4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        hz[7] = '{4'd5, 4'd0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // rw, wa, ra1, ra2, aluRes -> fwdAE, fwdBE
        prog[0] = '{1'b1, 4'd1, 4'd0, 4'd0, 16'h0005, 2'b00, 2'b00};
        prog[1] = '{1'b1, 4'd2, 4'd1, 4'd1, 16'h000A, 2'b10, 2'b10};
        prog[2] = '{1'b1, 4'd4, 4'd1, 4'd3, 16'h0015, 2'b01, 2'b00};
        prog[3] = '{1'b1, 4'd1, 4'd2, 4'd4, 16'h0007, 2'b01, 2'b10};
        prog[4] = '{1'b0, 4'd1, 4'd1, 4'd1, 16'h0009, 2'b10, 2'b10};
        prog[5] = '{1'b0, 4'd0, 4'd1, 4'd1, 16'h0000, 2'b01, 2'b01};
        prog[6] = '{1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 2'b00, 2'b00};
        prog[7] = '{1'b1, 4'd9, 4'd0, 4'd0, 16'hFFFF, 2'b00, 2'b00};

        idle_e();
        ra1D = '0; ra2D = '0; rdMemData = '0; memReady = 1'b1; clrCnt = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk("rst_stallCnt", stallCnt, 0);
        chk("rst_regWriteW", regWriteW, 0);
        chk("rst_memReqM", memReqM, 0);
        chk("rst_resultW", resultW, 0);
        chk("rst_fwd", {fwdAE, fwdBE}, 0);
        chk("rst_stalls", {stallF, stallD, flushD, flushE}, 0);

        // reset while a store is waiting on memory
        memWriteE = 1'b1; aluResE = 16'h0040; wdE = 24'h000ABC;
        tick();
        memReady = 1'b0;
        #1;
        chk("midacc_memReqM", memReqM, 1);
        chk("midacc_stallF", stallF, 1);
        tick();
        do_reset();
        chk("midacc_rst_memReqM", memReqM, 0);
        chk("midacc_rst_memWriteM", memWriteM, 0);
        chk("midacc_rst_regWriteW", regWriteW, 0);
        chk("midacc_rst_stallCnt", stallCnt, 0);
        idle_e();
        memReady = 1'b1;

        // hazard table on an empty M stage
        for (int i = 0; i < 8; i++) begin
            ra1D = hz[i].ra1D; ra2D = hz[i].ra2D; WA3E = hz[i].wa;
            regWriteE = hz[i].rw; memToRegE = hz[i].m2r; pcSrcE = hz[i].pc;
            #1;
            chk($sformatf("hz%0d", i), {stallF, stallD, flushD, flushE},
                {hz[i].sf, hz[i].sd, hz[i].fd, hz[i].fe});
        end
        idle_e();
        ra1D = '0; ra2D = '0;

        // ALU chain with forwarding, W results checked through the scoreboard
        do_reset();
        for (int i = 0; i < 8; i++) begin
            regWriteE = prog[i].rw; WA3E = prog[i].wa;
            ra1E = prog[i].ra1; ra2E = prog[i].ra2; aluResE = prog[i].res;
            #1;
            chk($sformatf("fwdA%0d", i), fwdAE, prog[i].fa);
            chk($sformatf("fwdB%0d", i), fwdBE, prog[i].fb);
            sbq.push_back('{cyc + 2, prog[i].rw, prog[i].wa, {8'h00, prog[i].res}});
            tick();
            pop_due();
        end
        idle_e();
        for (int k = 0; k < 8 && sbq.size() > 0; k++) begin
            tick();
            pop_due();
        end
        chk("sb_drained", sbq.size(), 0);

        // load-use: one stall cycle, then W-forwarding of the loaded value
        memToRegE = 1'b1; regWriteE = 1'b1; WA3E = 4'd3; aluResE = 16'h0100; ra1D = 4'd3;
        #1;
        chk("lu_stall", {stallF, stallD, flushD, flushE}, 4'b1101);
        tick();
        idle_e();
        rdMemData = 24'h00ABCD;
        #1;
        chk("lu_after_stallF", stallF, 0);
        chk("lu_memReqM", memReqM, 1);
        tick();
        ra1D = '0;
        ra1E = 4'd3; regWriteE = 1'b1; WA3E = 4'd8;
        #1;
        chk("lu_fwdAE", fwdAE, 2'b01);
        chk("lu_resultW", resultW, 24'h00ABCD);
        chk("lu_WA3W", WA3W, 3);
        idle_e();
        tick();

        // memory wait: 3 cycles of memReady low on a load
        clrCnt = 1'b1;
        tick();
        clrCnt = 1'b0;
        chk("mw_clr", stallCnt, 0);
        memToRegE = 1'b1; regWriteE = 1'b1; WA3E = 4'd5; aluResE = 16'h0200;
        tick();
        memToRegE = 1'b0; WA3E = 4'd6; aluResE = 16'h0033;
        memReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mw_stall", {stallF, stallD, flushE}, 3'b110);
            chk("mw_addr", memAddrM, 16'h0200);
            tick();
            chk("mw_bubble", regWriteW, 0);
            chk("mw_cnt", stallCnt, k + 1);
        end
        memReady = 1'b1; rdMemData = 24'h5A5A5A;
        #1;
        chk("mw_ready_stallF", stallF, 0);
        tick();
        chk("mw_resultW", resultW, 24'h5A5A5A);
        chk("mw_WA3W", WA3W, 5);
        chk("mw_regWriteW", regWriteW, 1);
        chk("mw_cnt_final", stallCnt, 3);
        idle_e();
        tick();
        chk("mw_next_WA3W", WA3W, 6);
        chk("mw_next_resultW", resultW, 24'h000033);

        // branch beats load-use; memStall beats branch
        pcSrcE = 1'b1; memToRegE = 1'b1; regWriteE = 1'b1; WA3E = 4'd7; ra1D = 4'd7;
        #1;
        chk("br_lu", {stallF, stallD, flushD, flushE}, 4'b0011);
        idle_e();
        ra1D = '0;
        memWriteE = 1'b1; aluResE = 16'h0300; wdE = 24'h123456;
        tick();
        idle_e();
        pcSrcE = 1'b1;
        memReady = 1'b0;
        #1;
        chk("br_ms", {stallF, stallD, flushD, flushE}, 4'b1100);
        chk("br_ms_wd", memWDM, 24'h123456);
        tick();
        chk("br_ms_hold", memWriteM, 1);
        memReady = 1'b1;
        #1;
        chk("br_release", {stallF, stallD, flushD, flushE}, 4'b0011);
        tick();
        idle_e();
        #1;
        chk("br_memWriteM", memWriteM, 0);
        tick();
        chk("br_pcSrcW", pcSrcW, 1);

        // counter saturation and clear-over-increment
        clrCnt = 1'b1;
        tick();
        clrCnt = 1'b0;
        memWriteE = 1'b1; aluResE = 16'h0400;
        tick();
        idle_e();
        memReady = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("cnt_sat", stallCnt, 15);
        clrCnt = 1'b1;
        tick();
        chk("cnt_clr_wins", stallCnt, 0);
        clrCnt = 1'b0;
        tick();
        chk("cnt_restart", stallCnt, 1);
        memReady = 1'b1;
        tick();
        chk("cnt_idle", stallCnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
